led_onehot_driver: RTL and testbench

//  Registered, parametrised one-hot LED driver for the Mastermind board; successor to the 3-to-8 mode decoder.

---
 rtl/led_pkg.sv | 17 +
 rtl/led_tick_gen.sv | 32 +++
 rtl/led_onehot_driver.sv | 127 ++++++++++++
 tb/tb_led_onehot_driver.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the one-hot LED driver.
// Used by led_tick_gen and led_onehot_driver.
package led_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      SWEEP = 2'd2
   } state_t;

   localparam int STEP_CNT_DEF = 25_000_000;

   function automatic int out_w(input int sel_w, input int bank_w);
      return 2 ** (sel_w + bank_w);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running 0..STEP_CNT-1 tick counter with synchronous clear.
// tick is high for the single cycle the counter sits on its terminal count.
module led_tick_gen
   import led_pkg::*;
#(
   parameter int STEP_CNT = STEP_CNT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int             CNT_W = (STEP_CNT > 2) ? $clog2(STEP_CNT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CNT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      if (clr || tick) cnt_d = '0;
      else             cnt_d = cnt_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/led_onehot_driver.sv
// Registered one-hot LED driver with SHOW/SWEEP modes for the Mastermind board.
// Define LED_BLINK_EN to blink the lit LED in SHOW once per tick.
module led_onehot_driver
   import led_pkg::*;
#(
   parameter  int SEL_W    = 2,
   parameter  int BANK_W   = 1,
   parameter  int STEP_CNT = STEP_CNT_DEF,
   localparam int IDX_W    = SEL_W + BANK_W,
   localparam int OUT_W    = out_w(SEL_W, BANK_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BANK_W-1:0] modo,
   input  logic [SEL_W-1:0]  sel,
   input  logic              load,
   input  logic              sweep_req,
   input  logic              clear,
   output logic [OUT_W-1:0]  leds,
   output logic              busy,
   output logic              sweep_done
);

   localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] pos_q, pos_d;
   logic [OUT_W-1:0] leds_q, leds_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tick, tick_clr;
`ifdef LED_BLINK_EN
   logic             blink_q, blink_d;
`endif

   led_tick_gen #(.STEP_CNT(STEP_CNT)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tick_clr),
      .tick  (tick)
   );

   always_comb begin
      // NOTE: every _d gets a default first so no path infers a latch.
      state_d  = state_q;
      idx_d    = idx_q;
      pos_d    = pos_q;
      done_d   = 1'b0;
      tick_clr = 1'b0;
`ifdef LED_BLINK_EN
      blink_d  = blink_q;
`endif
      // Strobe priority: clear > load > sweep_req; each restarts the tick phase.
      if (clear) begin
         state_d  = IDLE;
         tick_clr = 1'b1;
      end else if (load) begin
         state_d  = SHOW;
         idx_d    = {modo, sel};
         tick_clr = 1'b1;
`ifdef LED_BLINK_EN
         blink_d  = 1'b1;
`endif
      end else if (sweep_req) begin
         state_d  = SWEEP;
         pos_d    = '0;
         tick_clr = 1'b1;
      end else if (tick) begin
         case (state_q)
            SWEEP: begin
               if (&pos_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  pos_d = pos_q + 1'b1;
               end
            end
`ifdef LED_BLINK_EN
            SHOW:    blink_d = ~blink_q;
`endif
            default: ;
         endcase
      end

      leds_d = '0;
      case (state_d)
`ifdef LED_BLINK_EN
         SHOW:    leds_d = blink_d ? (ONE << idx_d) : '0;
`else
         SHOW:    leds_d = ONE << idx_d;
`endif
         SWEEP:   leds_d = ONE << pos_d;
         default: ;
      endcase
      busy_d = (state_d == SWEEP);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         pos_q   <= '0;
         leds_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef LED_BLINK_EN
         blink_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pos_q   <= pos_d;
         leds_q  <= leds_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef LED_BLINK_EN
         blink_q <= blink_d;
`endif
      end
   end

   assign leds       = leds_q;
   assign busy       = busy_q;
   assign sweep_done = done_q;

endmodule

// File: tb/tb_led_onehot_driver.sv
// Directed self-checking bench for led_onehot_driver with STEP_CNT=4.
// Honours LED_BLINK_EN for the SHOW blink expectations.
module tb_led_onehot_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [0:0] modo;
   logic [1:0] sel;
   logic       load, sweep_req, clear;
   logic [7:0] leds;
   logic       busy, sweep_done;

   int n_checks = 0;
   int n_fail   = 0;

   // Hand-computed one-hot codes for {modo,sel} = 0..7.
   logic [7:0] exp_load [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                8'h10, 8'h20, 8'h40, 8'h80};
   logic [7:0] exp_sweep [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                 8'h10, 8'h20, 8'h40, 8'h80};

   led_onehot_driver #(.SEL_W(2), .BANK_W(1), .STEP_CNT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .modo       (modo),
      .sel        (sel),
      .load       (load),
      .sweep_req  (sweep_req),
      .clear      (clear),
      .leds       (leds),
      .busy       (busy),
      .sweep_done (sweep_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic no_done_for(input int n, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         if (sweep_done) seen = 1'b1;
      end
      check(tag, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; modo = '0; sel = '0;
      load = 1'b0; sweep_req = 1'b0; clear = 1'b0;
      step(2);
      check("reset_leds", {24'd0, leds}, 32'h00);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, sweep_done}, 32'd0);
      rst_n = 1'b1;
      step();
      check("idle_leds", {24'd0, leds}, 32'h00);

      // Exhaustive load
      for (int m = 0; m < 2; m++) begin
         for (int s = 0; s < 4; s++) begin
            modo = m[0:0]; sel = s[1:0]; load = 1'b1;
            step();
            load = 1'b0;
            check($sformatf("load_m%0d_s%0d", m, s), {24'd0, leds}, {24'd0, exp_load[m*4+s]});
         end
      end
      check("show_busy", {31'd0, busy}, 32'd0);
      modo = 1'b0; sel = 2'd0;
      step();
      check("sel_ignored", {24'd0, leds}, 32'h80);

      // SHOW steady or blinking
      modo = 1'b0; sel = 2'd1; load = 1'b1;
      step();
      load = 1'b0;
      for (int k = 0; k < 12; k++) begin
`ifdef LED_BLINK_EN
         check($sformatf("blink_%0d", k), {24'd0, leds}, ((k / 4) % 2 == 0) ? 32'h02 : 32'h00);
`else
         check($sformatf("steady_%0d", k), {24'd0, leds}, 32'h02);
`endif
         step();
      end

      // Full sweep
      sweep_req = 1'b1;
      step();
      sweep_req = 1'b0;
      for (int p = 0; p < 8; p++) begin
         for (int c = 0; c < 4; c++) begin
            check($sformatf("sweep_p%0d_c%0d", p, c), {24'd0, leds}, {24'd0, exp_sweep[p]});
            check($sformatf("sweep_busy_p%0d_c%0d", p, c), {31'd0, busy}, 32'd1);
            check($sformatf("sweep_nodone_p%0d_c%0d", p, c), {31'd0, sweep_done}, 32'd0);
            step();
         end
      end
      check("sweep_end_leds", {24'd0, leds}, 32'h00);
      check("sweep_end_done", {31'd0, sweep_done}, 32'd1);
      check("sweep_end_busy", {31'd0, busy}, 32'd0);
      step();
      check("sweep_done_1cyc", {31'd0, sweep_done}, 32'd0);

      // Abort mid-sweep: load wins over a simultaneous sweep_req
      sweep_req = 1'b1;
      step();
      sweep_req = 1'b0;
      step(10);
      check("abort_pre_leds", {24'd0, leds}, 32'h04);
      modo = 1'b0; sel = 2'd3; load = 1'b1; sweep_req = 1'b1;
      step();
      load = 1'b0; sweep_req = 1'b0;
      check("abort_leds", {24'd0, leds}, 32'h08);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_nodone", {31'd0, sweep_done}, 32'd0);
      no_done_for(40, "abort_no_done_later");

      // clear wins over load
      modo = 1'b1; sel = 2'd3; load = 1'b1; clear = 1'b1;
      step();
      load = 1'b0; clear = 1'b0;
      check("load_clear_leds", {24'd0, leds}, 32'h00);
      check("load_clear_busy", {31'd0, busy}, 32'd0);

      // sweep_req during SWEEP restarts at LED 0 with a fresh tick phase
      sweep_req = 1'b1;
      step();
      sweep_req = 1'b0;
      step(6);
      check("restart_pre", {24'd0, leds}, 32'h02);
      sweep_req = 1'b1;
      step();
      sweep_req = 1'b0;
      check("restart_pos0", {24'd0, leds}, 32'h01);
      step(3);
      check("restart_hold", {24'd0, leds}, 32'h01);
      step();
      check("restart_pos1", {24'd0, leds}, 32'h02);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clear_sweep_leds", {24'd0, leds}, 32'h00);
      check("clear_sweep_busy", {31'd0, busy}, 32'd0);

      // Reset mid-sweep at step 3
      sweep_req = 1'b1;
      step();
      sweep_req = 1'b0;
      step(12);
      check("rst_pre_leds", {24'd0, leds}, 32'h08);
      rst_n = 1'b0;
      step();
      check("rst_mid_leds", {24'd0, leds}, 32'h00);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_done", {31'd0, sweep_done}, 32'd0);
      rst_n = 1'b1;
      no_done_for(40, "rst_no_done_later");
      check("rst_idle_leds", {24'd0, leds}, 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
